// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Pointer width carries one extra wrap bit so full and empty are distinguishable.
    function automatic int fifo_addr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, not reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard/FWFT read modes, thresholds,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  DEPTH      = 16,
    parameter int  AF_THRESH  = DEPTH - 2,
    parameter int  AE_THRESH  = 2,
    parameter bit  FWFT       = 1'b0,
    localparam int ADDR_WIDTH = fifo_addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_write,
    input  logic                  fifo_read,
    input  logic                  fifo_clear,
    output logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [ADDR_WIDTH-1:0] fifo_count,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] AF_CNT = ADDR_WIDTH'(AF_THRESH);
    localparam logic [ADDR_WIDTH-1:0] AE_CNT = ADDR_WIDTH'(AE_THRESH);
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

    if ((AF_THRESH < 0) || (AF_THRESH > DEPTH) || (AE_THRESH < 0) || (AE_THRESH > DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: AF_THRESH/AE_THRESH must lie in 0..DEPTH");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_dout;

    fifo_status_t          w_st;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    always_comb begin
        w_st              = '0;
        w_st.full         = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                            (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
        w_st.empty        = (r_wr_ptr == r_rd_ptr);
        w_st.almost_full  = (r_count >= AF_CNT);
        w_st.almost_empty = (r_count <= AE_CNT);
    end

    assign w_wr_acc = fifo_write && !w_st.full;
    assign w_rd_acc = fifo_read && !w_st.empty;
    // Storage must not see writes that rst/clear are dropping this cycle.
    assign w_ram_we = w_wr_acc && !rst && !fifo_clear;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr[IDX_W-1:0]),
        .i_wdata (fifo_data_in),
        .i_raddr (r_rd_ptr[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_valid     <= 1'b0;
            r_dout      <= '0;
        end else if (fifo_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
            if (fifo_write && w_st.full)  r_overflow  <= 1'b1;
            if (fifo_read  && w_st.empty) r_underflow <= 1'b1;
            r_valid <= w_rd_acc;
            if (w_rd_acc) r_dout <= w_rdata;
        end
    end

    assign fifo_data_out     = FWFT ? w_rdata : r_dout;
    assign fifo_valid        = FWFT ? !w_st.empty : r_valid;
    assign fifo_full         = w_st.full;
    assign fifo_empty        = w_st.empty;
    assign fifo_almost_full  = w_st.almost_full;
    assign fifo_almost_empty = w_st.almost_empty;
    assign fifo_count        = r_count;
    assign fifo_overflow     = r_overflow;
    assign fifo_underflow    = r_underflow;

endmodule
